// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: 4-digit time-multiplexed scan controller feeding a
// seven-segment decoder. Frame-synchronous value update, per-slot blank
// guard interval to stop ghosting, optional leading-zero blanking.
module sevenseg_scanner #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic        dig_en,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GRD  = CW'(GUARD);

  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   shadow, shadow_nx, disp, disp_nx;
  logic [3:0]    shadow_dp, shadow_dp_nx, disp_dp, disp_dp_nx;
  logic          pending, pending_nx;
  logic          wrap, boundary;

  logic [3:0]    nibble_nx, an_nx;
  logic          dig_en_nx, dp_nx;
  logic          guard_nx, lz_nx;

  // Slot counter / digit index advance, frame-boundary value handoff.
  always_comb begin
    wrap         = (cnt == LAST);
    boundary     = wrap && (idx == 2'd3);
    cnt_nx       = wrap ? '0 : cnt + CW'(1);
    idx_nx       = wrap ? idx + 2'd1 : idx;
    shadow_nx    = shadow;
    shadow_dp_nx = shadow_dp;
    pending_nx   = pending;
    disp_nx      = disp;
    disp_dp_nx   = disp_dp;
    if (boundary) begin
      // A load on the boundary itself goes straight to the display and
      // supersedes any older shadow.
      pending_nx = 1'b0;
      if (load) begin
        disp_nx    = value;
        disp_dp_nx = dp_in;
      end else if (pending) begin
        disp_nx    = shadow;
        disp_dp_nx = shadow_dp;
      end
    end else if (load) begin
      shadow_nx    = value;
      shadow_dp_nx = dp_in;
      pending_nx   = 1'b1;
    end
  end

  // Output decode from next-state so the registered outputs line up with
  // the cnt/idx they describe.
  always_comb begin
    guard_nx  = (cnt_nx < GRD);
    nibble_nx = disp_nx[{idx_nx, 2'b00} +: 4];
    case (idx_nx)
      2'd1:    lz_nx = (disp_nx[15:4] == 12'h000);
      2'd2:    lz_nx = (disp_nx[15:8] == 8'h00);
      2'd3:    lz_nx = (disp_nx[15:12] == 4'h0);
      default: lz_nx = 1'b0;
    endcase
    an_nx     = 4'b0000;
    dig_en_nx = 1'b0;
    dp_nx     = 1'b0;
    if (!guard_nx) begin
      an_nx     = 4'b0001 << idx_nx;
      dp_nx     = disp_dp_nx[idx_nx];
      dig_en_nx = !(blank_lz && lz_nx);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      pending   <= 1'b0;
      disp      <= 16'h0000;
      disp_dp   <= 4'h0;
      nibble    <= 4'h0;
      dig_en    <= 1'b0;
      an        <= 4'b0000;
      dp        <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      shadow    <= shadow_nx;
      shadow_dp <= shadow_dp_nx;
      pending   <= pending_nx;
      disp      <= disp_nx;
      disp_dp   <= disp_dp_nx;
      nibble    <= nibble_nx;
      dig_en    <= dig_en_nx;
      an        <= an_nx;
      dp        <= dp_nx;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with DIV=8, GUARD=2 (32-cycle frame).
module tb_sevenseg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic        dig_en;
  logic [3:0]  an;
  logic        dp;

  int tests = 0;
  int fails = 0;
  int k = 0;  // clock edges since reset release

  sevenseg_scanner #(.DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .nibble(nibble), .dig_en(dig_en), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Frame position reference for the expectation function.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else        k <= k + 1;

  // Expected {an, nibble, dig_en, dp} at frame position pos for a displayed value.
  function automatic logic [9:0] exp_out(logic [15:0] v, logic [3:0] dpv,
                                         logic blz, int pos);
    int d, c;
    logic [3:0] a, n;
    logic e, p, z;
    d = (pos / 8) % 4;
    c = pos % 8;
    n = v[d*4 +: 4];
    a = 4'b0000; e = 1'b0; p = 1'b0;
    if (c >= 2) begin
      a = 4'b0001 << d;
      p = dpv[d];
      z = 1'b1;
      for (int j = d; j < 4; j++) if (v[j*4 +: 4] != 4'h0) z = 1'b0;
      e = !(blz && d != 0 && z);
    end
    return {a, n, e, p};
  endfunction

  task automatic goto(input int p);
    for (int i = 0; i < 40 && (k % 32) != p; i++) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] got;
    repeat (2) @(negedge clk);
    got = {an, nibble, dig_en, dp};
    tests++;
    if (got !== 10'h000) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", got, 10'h000);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 11; n++) begin
      got = {an, nibble, dig_en, dp};
      tests++;
      if (got !== exp_out(16'h0, 4'h0, 1'b0, k)) begin
        fails++; $display("FAIL reset_scan pos=%0d got=%h exp=%h", k, got, exp_out(16'h0, 4'h0, 1'b0, k));
      end
      if (n == 10) begin
        tests++;
        if (an !== 4'b0010) begin
          fails++; $display("FAIL second_slot_an got=%b exp=0010", an);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_midframe;
    logic [9:0] got, ex;
    goto(12);
    do_load(16'h1A2F, 4'b0100);
    while ((k % 32) != 0) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h0, 4'h0, 1'b0, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL load_no_tear pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 32; n++) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h1A2F, 4'b0100, 1'b0, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL load_frame pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blank_lz;
    logic [9:0] got, ex;
    blank_lz = 1'b1;
    do_load(16'h0005, 4'h0);
    goto(0);
    for (int n = 0; n < 32; n++) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h0005, 4'h0, 1'b1, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL blank_0005 pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
    do_load(16'h0000, 4'h0);
    goto(0);
    for (int n = 0; n < 32; n++) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h0000, 4'h0, 1'b1, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL blank_0000 pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [9:0] got, ex;
    goto(4);
    do_load(16'h1111, 4'h0);
    goto(20);
    do_load(16'h2222, 4'h0);
    while ((k % 32) != 0) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h0000, 4'h0, 1'b0, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL b2b_old pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 32; n++) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h2222, 4'h0, 1'b0, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL b2b_last_wins pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boundary_load;
    logic [9:0] got, ex;
    goto(10);
    do_load(16'h1234, 4'hF);
    goto(31);
    do_load(16'hBEEF, 4'b0001);
    tests++;
    if (dut.pending !== 1'b0) begin
      fails++; $display("FAIL boundary_pending got=%b exp=0", dut.pending);
    end
    for (int n = 0; n < 64; n++) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'hBEEF, 4'b0001, 1'b0, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL boundary_frame pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] got, ex;
    goto(18);
    do_load(16'h7777, 4'hF);
    @(negedge clk);
    got = {an, nibble, dig_en, dp}; ex = exp_out(16'hBEEF, 4'b0001, 1'b0, 20);
    tests++;
    if (got !== ex) begin
      fails++; $display("FAIL pre_reset got=%h exp=%h", got, ex);
    end
    #2 rst_n = 1'b0;
    #1 got = {an, nibble, dig_en, dp};
    tests++;
    if (got !== 10'h000) begin
      fails++; $display("FAIL async_reset got=%h exp=%h", got, 10'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 64; n++) begin
      got = {an, nibble, dig_en, dp}; ex = exp_out(16'h0000, 4'h0, 1'b0, k % 32);
      tests++;
      if (got !== ex) begin
        fails++; $display("FAIL post_reset pos=%0d got=%h exp=%h", k % 32, got, ex);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_load_midframe;
    test_blank_lz;
    test_back_to_back;
    test_boundary_load;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
